// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory bus arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - owner_t     : owner_o codes (none / instruction / data)
//   - AW          : address and data width
package mem_arb_pkg;

  localparam int AW = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    INSTR = 2'b01,
    DATA  = 2'b10
  } owner_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: transaction timeout counter for the memory bus arbiter.
// This is a down-counter: clear loads LIMIT-1, and each enabled cycle
// decrements it. expired is raised on the LIMIT-th enabled cycle after a clear.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-low reset
//   clear        : reload the counter (held while the arbiter is idle)
//   enable       : count this cycle (busy and no ack)
//   expired      : terminal count reached during an enabled cycle
module mem_arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory port between the instruction
// and data uncached request paths. Data has priority; after STARVE_LIMIT
// consecutive data grants with an instruction request waiting, the next
// grant goes to instruction.
// Optional feature macro: MEM_ARB_TIMEOUT_EN enables a busy watchdog that
// aborts a transaction after TIMEOUT_CYCLES cycles without mem_ack_i and
// pulses bus_error_o with the ready pulse.
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-low reset
//   i_req_i, i_addr_i            : instruction request / address
//   i_data_o, i_ready_o          : instruction read data / completion pulse
//   d_req_i, d_wr_i, d_addr_i,
//   d_wdata_i, d_bytesel_i       : data request, direction, address, wdata, byte enables
//   d_data_o, d_ready_o          : data read data / completion pulse
//   mem_cs_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_bytesel_o   : memory port request side
//   mem_rdata_i, mem_ack_i       : memory port response side
//   owner_o                      : current grant (00 none, 01 instr, 10 data)
//   bus_error_o                  : watchdog abort pulse
//
// state  | meaning
// IDLE   | arbitrate between pending requests
// BUSY_I | instruction transaction on memory port, waiting for ack
// BUSY_D | data transaction on memory port, waiting for ack
// RESP_I | instruction ready pulse, memory port released
// RESP_D | data ready pulse, memory port released
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_req_i,
  input  logic [AW-1:0] i_addr_i,
  output logic [AW-1:0] i_data_o,
  output logic          i_ready_o,
  input  logic          d_req_i,
  input  logic          d_wr_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [AW-1:0] d_wdata_i,
  input  logic [3:0]    d_bytesel_i,
  output logic [AW-1:0] d_data_o,
  output logic          d_ready_o,
  output logic          mem_cs_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [AW-1:0] mem_wdata_o,
  output logic [3:0]    mem_bytesel_o,
  input  logic [AW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic [1:0]    owner_o,
  output logic          bus_error_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_bus_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be >= 1");
  end

  arb_state_t    state, state_nxt;
  logic [SW-1:0] streak;
  logic          grant_i, grant_d;
  logic          busy;
  logic          timeout;

  assign busy = (state == BUSY_I) || (state == BUSY_D);

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q;

  mem_arb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (state == IDLE),
    .enable (busy && !mem_ack_i),
    .expired(timeout)
  );

  // Set on the abort edge, so it is high exactly during the RESP cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= busy && timeout;
  end

  assign bus_error_o = err_q;
`else
  assign timeout     = 1'b0;
  assign bus_error_o = 1'b0;
`endif

  // Arbitration, only meaningful in IDLE.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_req_i && d_req_i) begin
        if (streak == STREAK_MAX) grant_i = 1'b1;
        else                      grant_d = 1'b1;
      end else if (i_req_i) begin
        grant_i = 1'b1;
      end else if (d_req_i) begin
        grant_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_nxt = BUSY_I;
        else if (grant_d) state_nxt = BUSY_D;
      end
      BUSY_I: if (mem_ack_i || timeout) state_nxt = RESP_I;
      BUSY_D: if (mem_ack_i || timeout) state_nxt = RESP_D;
      RESP_I, RESP_D: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from the state register only, so reset drops mem_cs_o at once.
  always_comb begin
    mem_cs_o  = 1'b0;
    i_ready_o = 1'b0;
    d_ready_o = 1'b0;
    owner_o   = NONE;
    case (state)
      BUSY_I: begin mem_cs_o  = 1'b1; owner_o = INSTR; end
      BUSY_D: begin mem_cs_o  = 1'b1; owner_o = DATA;  end
      RESP_I: begin i_ready_o = 1'b1; owner_o = INSTR; end
      RESP_D: begin d_ready_o = 1'b1; owner_o = DATA;  end
      default: ;
    endcase
  end

  // Request capture and response data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_bytesel_o <= '0;
      i_data_o      <= '0;
      d_data_o      <= '0;
    end else begin
      if (grant_i) begin
        mem_addr_o    <= i_addr_i;
        mem_we_o      <= 1'b0;
        mem_bytesel_o <= 4'b1111;
      end else if (grant_d) begin
        mem_addr_o    <= d_addr_i;
        mem_we_o      <= d_wr_i;
        mem_wdata_o   <= d_wdata_i;
        mem_bytesel_o <= d_bytesel_i;
      end
      if (state == BUSY_I) begin
        if (mem_ack_i)    i_data_o <= mem_rdata_i;
        else if (timeout) i_data_o <= '0;
      end
      if (state == BUSY_D) begin
        if (mem_ack_i)    d_data_o <= mem_rdata_i;
        else if (timeout) d_data_o <= '0;
      end
    end
  end

  // Consecutive data grants made while instruction waits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      streak <= '0;
    end else if (grant_i) begin
      streak <= '0;
    end else if (grant_d) begin
      if (!i_req_i)                 streak <= '0;
      else if (streak != STREAK_MAX) streak <= streak + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (STARVE_LIMIT=4,
// TIMEOUT_CYCLES=8). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point.
module tb_mem_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_data_o;
  logic        i_ready_o;
  logic        d_req_i;
  logic        d_wr_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_bytesel_i;
  logic [31:0] d_data_o;
  logic        d_ready_o;
  logic        mem_cs_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_bytesel_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [1:0]  owner_o;
  logic        bus_error_o;

  int checks = 0;
  int passes = 0;

  always #5 clk_i = ~clk_i;

  mem_bus_arbiter #(
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_req_i      (i_req_i),
    .i_addr_i     (i_addr_i),
    .i_data_o     (i_data_o),
    .i_ready_o    (i_ready_o),
    .d_req_i      (d_req_i),
    .d_wr_i       (d_wr_i),
    .d_addr_i     (d_addr_i),
    .d_wdata_i    (d_wdata_i),
    .d_bytesel_i  (d_bytesel_i),
    .d_data_o     (d_data_o),
    .d_ready_o    (d_ready_o),
    .mem_cs_o     (mem_cs_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_bytesel_o(mem_bytesel_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .owner_o      (owner_o),
    .bus_error_o  (bus_error_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    i_req_i = 0; i_addr_i = 0; d_req_i = 0; d_wr_i = 0; d_addr_i = 0;
    d_wdata_i = 0; d_bytesel_i = 0; mem_rdata_i = 0; mem_ack_i = 0;
    step(); step();
    checks++; if (mem_cs_o !== 1'b0) $display("FAIL rst_cs got=%b exp=0", mem_cs_o); else passes++;
    checks++; if (owner_o !== 2'b00) $display("FAIL rst_owner got=%b exp=00", owner_o); else passes++;
    checks++; if ({i_ready_o, d_ready_o, bus_error_o, mem_we_o} !== 4'b0) $display("FAIL rst_flags got=%b exp=0000", {i_ready_o, d_ready_o, bus_error_o, mem_we_o}); else passes++;
    checks++; if ({mem_addr_o, mem_wdata_o, mem_bytesel_o} !== 68'h0) $display("FAIL rst_mem got=%h exp=0", {mem_addr_o, mem_wdata_o, mem_bytesel_o}); else passes++;
    checks++; if ({i_data_o, d_data_o} !== 64'h0) $display("FAIL rst_data got=%h exp=0", {i_data_o, d_data_o}); else passes++;
    rst_i = 1'b1;
    step();
    checks++; if (owner_o !== 2'b00) $display("FAIL rst_idle_owner got=%b exp=00", owner_o); else passes++;
  endtask

  task automatic test_data_read();
    d_req_i = 1; d_wr_i = 0; d_addr_i = 32'h1000_0040; d_bytesel_i = 4'b1111;
    step();
    checks++; if (mem_cs_o !== 1'b1) $display("FAIL rd_cs got=%b exp=1", mem_cs_o); else passes++;
    checks++; if (mem_addr_o !== 32'h1000_0040) $display("FAIL rd_addr got=%h exp=10000040", mem_addr_o); else passes++;
    checks++; if (mem_we_o !== 1'b0) $display("FAIL rd_we got=%b exp=0", mem_we_o); else passes++;
    checks++; if (owner_o !== 2'b10) $display("FAIL rd_owner got=%b exp=10", owner_o); else passes++;
    step();
    checks++; if ({mem_cs_o, d_ready_o} !== 2'b10) $display("FAIL rd_wait got=%b exp=10", {mem_cs_o, d_ready_o}); else passes++;
    mem_ack_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    step();
    checks++; if ({d_ready_o, i_ready_o, mem_cs_o} !== 3'b100) $display("FAIL rd_ready got=%b exp=100", {d_ready_o, i_ready_o, mem_cs_o}); else passes++;
    checks++; if (d_data_o !== 32'hDEAD_BEEF) $display("FAIL rd_data got=%h exp=deadbeef", d_data_o); else passes++;
    mem_ack_i = 0; d_req_i = 0; mem_rdata_i = 32'h0;
    step();
    checks++; if ({d_ready_o, owner_o} !== 3'b000) $display("FAIL rd_idle got=%b exp=000", {d_ready_o, owner_o}); else passes++;
    checks++; if (d_data_o !== 32'hDEAD_BEEF) $display("FAIL rd_hold got=%h exp=deadbeef", d_data_o); else passes++;
  endtask

  task automatic test_write();
    d_req_i = 1; d_wr_i = 1; d_addr_i = 32'h2000_0008;
    d_wdata_i = 32'h0000_1234; d_bytesel_i = 4'b0011;
    step();
    checks++; if ({mem_cs_o, mem_we_o} !== 2'b11) $display("FAIL wr_cs_we got=%b exp=11", {mem_cs_o, mem_we_o}); else passes++;
    checks++; if (mem_bytesel_o !== 4'b0011) $display("FAIL wr_bytesel got=%b exp=0011", mem_bytesel_o); else passes++;
    checks++; if (mem_wdata_o !== 32'h0000_1234) $display("FAIL wr_wdata got=%h exp=00001234", mem_wdata_o); else passes++;
    // Disturb the data-side inputs; the captured request must not move.
    d_wr_i = 0; d_addr_i = 32'hFFFF_0000; d_wdata_i = 32'hCAFE_F00D; d_bytesel_i = 4'b1100;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({mem_cs_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_bytesel_o} !== {2'b11, 32'h2000_0008, 32'h0000_1234, 4'b0011})
        $display("FAIL wr_stable cycle=%0d got=%b_%b_%h_%h_%b exp=1_1_20000008_00001234_0011", c, mem_cs_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_bytesel_o);
      else passes++;
    end
    mem_ack_i = 1; mem_rdata_i = 32'h0000_5555;
    step();
    checks++; if ({d_ready_o, d_data_o} !== {1'b1, 32'h0000_5555}) $display("FAIL wr_ready got=%b/%h exp=1/00005555", d_ready_o, d_data_o); else passes++;
    mem_ack_i = 0; d_req_i = 0;
    step();
    checks++; if (i_data_o !== 32'h0) $display("FAIL wr_idata_hold got=%h exp=0", i_data_o); else passes++;
  endtask

  task automatic test_instr_read();
    i_req_i = 1; i_addr_i = 32'h0000_0100; mem_ack_i = 0;
    step();
    checks++; if ({owner_o, mem_we_o, mem_bytesel_o} !== {2'b01, 1'b0, 4'b1111}) $display("FAIL ir_grant got=%b_%b_%b exp=01_0_1111", owner_o, mem_we_o, mem_bytesel_o); else passes++;
    checks++; if (mem_addr_o !== 32'h0000_0100) $display("FAIL ir_addr got=%h exp=00000100", mem_addr_o); else passes++;
    mem_ack_i = 1; mem_rdata_i = 32'h2411_0001;
    step();
    checks++; if ({i_ready_o, d_ready_o, i_data_o} !== {2'b10, 32'h2411_0001}) $display("FAIL ir_ready got=%b%b/%h exp=10/24110001", i_ready_o, d_ready_o, i_data_o); else passes++;
    checks++; if (d_data_o !== 32'h0000_5555) $display("FAIL ir_ddata_hold got=%h exp=00005555", d_data_o); else passes++;
    mem_ack_i = 0; i_req_i = 0;
    step();
  endtask

  task automatic test_drop_after_grant();
    d_req_i = 1; d_wr_i = 0; d_addr_i = 32'h3000_0000;
    step();
    d_req_i = 0;
    step();
    checks++; if ({mem_cs_o, owner_o} !== 3'b110) $display("FAIL drop_hold got=%b exp=110", {mem_cs_o, owner_o}); else passes++;
    mem_ack_i = 1; mem_rdata_i = 32'h0BAD_CAFE;
    step();
    checks++; if ({d_ready_o, d_data_o} !== {1'b1, 32'h0BAD_CAFE}) $display("FAIL drop_ready got=%b/%h exp=1/0badcafe", d_ready_o, d_data_o); else passes++;
    mem_ack_i = 0;
    step();
    checks++; if (owner_o !== 2'b00) $display("FAIL drop_idle got=%b exp=00", owner_o); else passes++;
  endtask

  task automatic test_starvation();
    logic [1:0] exp_order [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                   2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    logic [1:0] prev = 2'b00;
    int         n = 0;
    i_req_i = 1; i_addr_i = 32'h0000_0200;
    d_req_i = 1; d_wr_i = 0; d_addr_i = 32'h1000_0080;
    mem_ack_i = 1; mem_rdata_i = 32'hA5A5_A5A5;
    for (int c = 0; c < 40 && n < 10; c++) begin
      step();
      if (prev == 2'b00 && owner_o != 2'b00) begin
        checks++;
        if (owner_o !== exp_order[n]) $display("FAIL starve_grant%0d got=%b exp=%b", n, owner_o, exp_order[n]);
        else passes++;
        n++;
      end
      prev = owner_o;
    end
    checks++; if (n != 10) $display("FAIL starve_count got=%0d exp=10", n); else passes++;
    i_req_i = 0; d_req_i = 0;
    step(); step(); step();
    mem_ack_i = 0;
    checks++; if (owner_o !== 2'b00) $display("FAIL starve_idle got=%b exp=00", owner_o); else passes++;
  endtask

  task automatic test_stray_ack();
    mem_ack_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
    step();
    mem_ack_i = 0;
    checks++; if ({owner_o, mem_cs_o, i_ready_o, d_ready_o} !== 5'b0) $display("FAIL stray_state got=%b exp=00000", {owner_o, mem_cs_o, i_ready_o, d_ready_o}); else passes++;
    step();
    checks++; if ({i_ready_o, d_ready_o} !== 2'b00) $display("FAIL stray_ready got=%b exp=00", {i_ready_o, d_ready_o}); else passes++;
    checks++; if ({i_data_o, d_data_o} !== {32'hA5A5_A5A5, 32'hA5A5_A5A5}) $display("FAIL stray_data got=%h exp=a5a5a5a5a5a5a5a5", {i_data_o, d_data_o}); else passes++;
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int busy_cycles = 0;
    logic seen = 1'b0;
    i_req_i = 1; i_addr_i = 32'h0000_0300; mem_ack_i = 0;
    step();
    i_req_i = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      busy_cycles++;
      if (i_ready_o) seen = 1'b1;
    end
    checks++; if (!seen || busy_cycles != 8) $display("FAIL to_latency got=%0d exp=8", busy_cycles); else passes++;
    checks++; if ({i_ready_o, bus_error_o, mem_cs_o} !== 3'b110) $display("FAIL to_pulse got=%b exp=110", {i_ready_o, bus_error_o, mem_cs_o}); else passes++;
    checks++; if (i_data_o !== 32'h0) $display("FAIL to_data got=%h exp=0", i_data_o); else passes++;
    step();
    checks++; if ({owner_o, bus_error_o, i_ready_o} !== 4'b0) $display("FAIL to_idle got=%b exp=0000", {owner_o, bus_error_o, i_ready_o}); else passes++;
  endtask
`else
  task automatic test_long_wait();
    logic bad = 1'b0;
    i_req_i = 1; i_addr_i = 32'h0000_0300; mem_ack_i = 0;
    step();
    i_req_i = 0;
    for (int c = 0; c < 20; c++) begin
      if ({mem_cs_o, i_ready_o, bus_error_o} !== 3'b100) bad = 1'b1;
      step();
    end
    checks++; if (bad) $display("FAIL lw_wait got=abort exp=wait"); else passes++;
    mem_ack_i = 1; mem_rdata_i = 32'h1357_9BDF;
    step();
    mem_ack_i = 0;
    checks++; if ({i_ready_o, bus_error_o, i_data_o} !== {2'b10, 32'h1357_9BDF}) $display("FAIL lw_ready got=%b%b/%h exp=10/13579bdf", i_ready_o, bus_error_o, i_data_o); else passes++;
    step();
  endtask
`endif

  task automatic test_reset_mid();
    logic rdy = 1'b0;
    d_req_i = 1; d_wr_i = 1; d_addr_i = 32'h4000_0010; d_wdata_i = 32'h7777_0000; d_bytesel_i = 4'b0110;
    step();
    checks++; if ({mem_cs_o, owner_o} !== 3'b110) $display("FAIL rm_busy got=%b exp=110", {mem_cs_o, owner_o}); else passes++;
    #2 rst_i = 1'b0;
    #1;
    checks++; if ({mem_cs_o, owner_o, mem_we_o} !== 4'b0) $display("FAIL rm_async got=%b exp=0000", {mem_cs_o, owner_o, mem_we_o}); else passes++;
    checks++; if ({mem_addr_o, mem_wdata_o, mem_bytesel_o, d_data_o, i_data_o} !== 132'h0) $display("FAIL rm_values got=%h exp=0", {mem_addr_o, mem_wdata_o, mem_bytesel_o, d_data_o, i_data_o}); else passes++;
    d_req_i = 0;
    mem_ack_i = 1;
    step();
    rst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (d_ready_o || i_ready_o || mem_cs_o) rdy = 1'b1;
    end
    mem_ack_i = 0;
    checks++; if (rdy) $display("FAIL rm_no_ready got=pulse exp=none"); else passes++;
  endtask

  initial begin
    test_reset();
    test_data_read();
    test_write();
    test_instr_read();
    test_drop_after_grant();
    test_starvation();
    test_stray_ack();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
